// File: rtl/atm_keypad_entry.sv
// Keypad entry engine: collects key strobes into a BCD password or a binary value.
// Optional inactivity timeout is compiled in with `define KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
  parameter int password_width = 16,
  parameter int balance_width  = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      entry_req,
  input  logic                      entry_kind,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic [password_width-1:0] password_out,
  output logic [balance_width-1:0]  value_out,
  output logic                      entry_done,
  output logic                      entry_abort,
  output logic                      key_reject,
  output logic [3:0]                digit_count,
  output logic                      busy
);

  localparam int PSW_DIGITS = password_width / 4;
  localparam int ACC_W      = (password_width > balance_width) ? password_width : balance_width;
  localparam int VW         = balance_width + 4;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CLEAR  = 4'hB;
  localparam logic [3:0] K_CANCEL = 4'hC;
  localparam logic [3:0] PSW_FULL = 4'(PSW_DIGITS);

  logic [0:0]                state_q, state_d;
  logic                      kind_q, kind_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [password_width-1:0] psw_q, psw_d;
  logic [balance_width-1:0]  val_q, val_d;
  logic                      done_q, done_d;
  logic                      abort_q, abort_d;
  logic                      reject_q, reject_d;

  // Shift a new BCD digit in at the bottom; the oldest digit ends up in the MS nibble.
  logic [password_width+3:0] psw_shift;
  logic [VW-1:0]             val_prod;
  logic                      val_ovf;

  assign psw_shift = {acc_q[password_width-1:0], key_code};
  assign val_prod  = VW'(acc_q[balance_width-1:0]) * VW'(10) + VW'(key_code);
  assign val_ovf   = |val_prod[VW-1:balance_width];

`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d  = state_q;
    kind_d   = kind_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    psw_d    = psw_q;
    val_d    = val_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    reject_d = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
    idle_d   = idle_q;
`endif

    if (state_q == S_IDLE) begin
      // A key strobe coinciding with entry_req is dropped on purpose.
      if (entry_req) begin
        state_d = S_COLLECT;
        kind_d  = entry_kind;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef KEYPAD_TIMEOUT_EN
        idle_d  = '0;
`endif
      end
    end else if (key_valid) begin
`ifdef KEYPAD_TIMEOUT_EN
      idle_d = '0;
`endif
      if (key_code <= 4'd9) begin
        if (!kind_q) begin
          if (cnt_q < PSW_FULL) begin
            acc_d = ACC_W'(psw_shift[password_width-1:0]);
            cnt_d = cnt_q + 4'd1;
          end else begin
            reject_d = 1'b1;
          end
        end else if (val_ovf) begin
          reject_d = 1'b1;
        end else begin
          acc_d = ACC_W'(val_prod[balance_width-1:0]);
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
      end else begin
        case (key_code)
          K_ENTER: begin
            if (cnt_q == 4'd0 || (!kind_q && cnt_q != PSW_FULL)) begin
              reject_d = 1'b1;
            end else begin
              if (kind_q) val_d = acc_q[balance_width-1:0];
              else        psw_d = acc_q[password_width-1:0];
              done_d  = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
          K_CLEAR: begin
            acc_d = '0;
            cnt_d = '0;
          end
          K_CANCEL: begin
            abort_d = 1'b1;
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
          default: reject_d = 1'b1;
        endcase
      end
    end
`ifdef KEYPAD_TIMEOUT_EN
    else if (idle_q == 32'(TIMEOUT_CYCLES - 1)) begin
      abort_d = 1'b1;
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kind_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      psw_q    <= '0;
      val_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      kind_q   <= kind_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      psw_q    <= psw_d;
      val_q    <= val_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      reject_q <= reject_d;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  assign password_out = psw_q;
  assign value_out    = val_q;
  assign entry_done   = done_q;
  assign entry_abort  = abort_q;
  assign key_reject   = reject_q;
  assign digit_count  = cnt_q;
  assign busy         = (state_q == S_COLLECT);

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Randomized scoreboard bench for atm_keypad_entry against a digit-level reference model.
// Build with +define+KEYPAD_TIMEOUT_EN to also exercise the inactivity timeout.
module tb_atm_keypad_entry;

  localparam int PW   = 16;
  localparam int BW   = 20;
  localparam int TMO  = 8;
  localparam int NDIG = PW / 4;
  localparam longint MAXV = (64'd1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          entry_req = 1'b0;
  logic          entry_kind = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'h0;
  logic [PW-1:0] password_out;
  logic [BW-1:0] value_out;
  logic          entry_done, entry_abort, key_reject, busy;
  logic [3:0]    digit_count;

  atm_keypad_entry #(.password_width(PW), .balance_width(BW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .entry_kind(entry_kind),
    .key_valid(key_valid), .key_code(key_code), .password_out(password_out),
    .value_out(value_out), .entry_done(entry_done), .entry_abort(entry_abort),
    .key_reject(key_reject), .digit_count(digit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [2:0] pulses;  // {done, abort, reject}
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: session held as a list of digits or an integer value.
  bit      m_busy, m_kind;
  int      m_digits[$];
  longint  m_val;
  int      m_cnt;
  int      m_quiet;
  logic [PW-1:0] m_psw;
  logic [BW-1:0] m_vout;

  function automatic void model_reset();
    m_busy = 0; m_kind = 0; m_digits.delete(); m_val = 0; m_cnt = 0; m_quiet = 0;
    m_psw = '0; m_vout = '0;
  endfunction

  function automatic void end_session();
    m_busy = 0; m_digits.delete(); m_val = 0; m_cnt = 0; m_quiet = 0;
  endfunction

  function automatic logic [2:0] model_step(bit req, bit kind, bit kv, logic [3:0] code);
    logic [2:0] p = 3'b000;
    if (!m_busy) begin
      if (req) begin
        end_session();
        m_busy = 1; m_kind = kind;
      end
    end else if (kv) begin
      m_quiet = 0;
      if (code <= 9) begin
        if (!m_kind) begin
          if (m_digits.size() < NDIG) begin m_digits.push_back(int'(code)); m_cnt++; end
          else p[0] = 1;
        end else if (m_val * 10 + longint'(code) > MAXV) begin
          p[0] = 1;
        end else begin
          m_val = m_val * 10 + longint'(code);
          if (m_cnt < 15) m_cnt++;
        end
      end else if (code == 4'hA) begin
        if (m_cnt == 0 || (!m_kind && m_cnt != NDIG)) p[0] = 1;
        else begin
          if (m_kind) m_vout = BW'(m_val);
          else begin
            m_psw = '0;
            foreach (m_digits[i]) m_psw = (m_psw << 4) | PW'(m_digits[i]);
          end
          p[2] = 1;
          end_session();
        end
      end else if (code == 4'hB) begin
        m_digits.delete(); m_val = 0; m_cnt = 0;
      end else if (code == 4'hC) begin
        p[1] = 1;
        end_session();
      end else begin
        p[0] = 1;
      end
    end
`ifdef KEYPAD_TIMEOUT_EN
    else if (m_quiet == TMO - 1) begin
      p[1] = 1;
      end_session();
    end else begin
      m_quiet++;
    end
`endif
    return p;
  endfunction

  task automatic step(input bit req, input bit kind, input bit kv, input logic [3:0] code);
    logic [2:0] p;
    exp_t e;
    @(negedge clk);
    entry_req = req; entry_kind = kind; key_valid = kv; key_code = code;
    p = model_step(req, kind, kv, code);
    if (p != 3'b000) begin
      e.cyc = cyc + 1; e.pulses = p;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    entry_req = 1'b0; key_valid = 1'b0;
    check("busy", 32'(busy), 32'(m_busy));
    check("digit_count", 32'(digit_count), 32'(m_cnt));
    check("password_out", 32'(password_out), 32'(m_psw));
    check("value_out", 32'(value_out), 32'(m_vout));
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b0, 1'b0, 1'b1, code);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_password", 32'(password_out), 32'd0);
    check("rst_value", 32'(value_out), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({entry_done, entry_abort, key_reject}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: whenever a pulse appears (or one is due), compare against the scoreboard.
  initial begin
    exp_t e;
    logic [2:0] act, exp;
    forever begin
      @(negedge clk);
      act = {entry_done, entry_abort, key_reject};
      exp = 3'b000;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc == cyc) exp = e.pulses;
        else check("pulse_late", 32'(e.cyc), 32'(cyc));
      end
      if (act != 3'b000 || exp != 3'b000) check("pulses", 32'(act), 32'(exp));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("por_password", 32'(password_out), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Password: early ENTER refused, then full entry accepted.
    step(1, 0, 0, 0);
    key(1); key(2); key(3); key(4'hA);
    key(4); key(4'hA);
    check("psw_1234", 32'(password_out), 32'h1234);

    // Value entry leaves the password alone.
    step(1, 1, 0, 0);
    key(1); key(2); key(3); key(4); key(4'hA);
    check("val_1234", 32'(value_out), 32'h004D2);

    // Value overflow on the seventh digit.
    step(1, 1, 0, 0);
    key(1); key(0); key(4); key(8); key(5); key(7); key(6);
    check("ovf_count", 32'(digit_count), 32'd6);
    key(4'hA);
    check("val_max", 32'(value_out), 32'h19999);

    // CLEAR then CANCEL; idle keys are ignored.
    step(1, 0, 0, 0);
    key(9); key(9); key(4'hB);
    key(5); key(4'hC);
    key(3);

    // Invalid code, password overfill, and a key dropped alongside entry_req.
    step(1, 0, 0, 0);
    key(4'hE);
    key(8); key(8); key(8); key(8); key(8); key(4'hF);
    key(4'hC);
    step(1, 0, 1, 7);
    key(4'hC);

    // Reset in the middle of a session.
    step(1, 1, 0, 0);
    key(3); key(2); key(1);
    apply_reset();

`ifdef KEYPAD_TIMEOUT_EN
    step(1, 0, 0, 0);
    repeat (TMO + 2) step(0, 0, 0, 0);
`endif

    // Randomized sessions.
    for (int i = 0; i < 1500; i++) begin
      bit req = ($urandom_range(0, 2) == 0);
      bit kind = $urandom_range(0, 1);
      bit kv = ($urandom_range(0, 9) < 7);
      int r = $urandom_range(0, 99);
      logic [3:0] code;
      if (r < 70)      code = 4'($urandom_range(0, 9));
      else if (r < 85) code = 4'hA;
      else if (r < 90) code = 4'hB;
      else if (r < 94) code = 4'hC;
      else             code = 4'($urandom_range(13, 15));
      step(req, kind, kv, code);
    end

    repeat (3) step(0, 0, 0, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
Front-panel keypad entry engine that drives the customer-side inputs of the ATM top: the password word and the transaction value.
- Accepts one key strobe at a time.
- Packs digits into a BCD password or accumulates them into a binary value.
- Signals completion or cancellation with single-cycle pulses.
- Sits between the keypad scanner and the ATM top; the transaction sequencer issues entry requests.

Parameters:
password_width, 16, password word width; digit capacity PSW_DIGITS = password_width/4 (must be 1..15)
balance_width, 20, value word width; maximum accepted value 2^balance_width-1
TIMEOUT_CYCLES, 1000, inactivity limit in clk cycles (used only with KEYPAD_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
entry_req  input  1  start an entry session; sampled only in IDLE
entry_kind  input  1  0 = password entry, 1 = value entry; latched with entry_req
key_valid  input  1  one-cycle key strobe
key_code  input  4  0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF invalid
password_out  output  password_width  last accepted password, BCD packed, first digit in MS nibble
value_out  output  balance_width  last accepted value, binary
entry_done  output  1  one-cycle pulse: entry accepted, matching output updated this cycle
entry_abort  output  1  one-cycle pulse: session cancelled (or timed out)
key_reject  output  1  one-cycle pulse: key sampled but refused
digit_count  output  4  digits currently held in the session accumulator
busy  output  1  high in COLLECT

Behaviour:
- Reset (async, rst=1) values:
  - State IDLE.
  - password_out=0, value_out=0, accumulator=0, digit_count=0.
  - busy=0, entry_done=0, entry_abort=0, key_reject=0.
- All outputs are registered. Pulses last exactly one cycle, in the cycle after the causing key is sampled.
- States: IDLE, COLLECT.
- IDLE:
  - key_valid is ignored, with no reject.
  - entry_req=1 latches entry_kind, clears the accumulator and digit_count, and moves to COLLECT. busy=1 from the next cycle.
  - If key_valid and entry_req occur in the same cycle, the key is dropped.
- COLLECT, on key_valid:
  - Digit, password kind:
    - If digit_count < PSW_DIGITS: acc <= {acc[password_width-5:0], digit} and digit_count++.
    - Otherwise key_reject.
  - Digit, value kind:
    - Compute acc*10+digit at balance_width+4 bits.
    - If the result > 2^balance_width-1: key_reject, acc unchanged.
    - Otherwise acc <= result and digit_count++ (saturates at 15; counting only).
  - ENTER:
    - Rejected if digit_count==0.
    - Rejected for a password with digit_count != PSW_DIGITS.
    - Otherwise copy acc to password_out or value_out (matching the kind), pulse entry_done, go to IDLE, clear digit_count.
  - CLEAR: acc=0, digit_count=0, stay in COLLECT, no pulse.
  - CANCEL: pulse entry_abort, go to IDLE. password_out and value_out are unchanged.
  - 0xD-0xF: key_reject, no state change.
- entry_req while in COLLECT is ignored.
- Outputs hold their last accepted value until the next accepted entry of the same kind. A value entry never alters password_out, and the reverse.
- Reset mid-session returns everything to reset values immediately; no pulse is produced.

Optional Feature:
KEYPAD_TIMEOUT_EN:
- Defined:
  - An inactivity counter clears on entering COLLECT and on every key_valid in COLLECT, and increments otherwise.
  - When the count reaches TIMEOUT_CYCLES-1 with no key: pulse entry_abort, go to IDLE, clear the accumulator. Outputs are unchanged.
  - A key arriving in the same cycle as the expiry wins; no abort.
- Undefined: no counter; a session persists until ENTER or CANCEL.

Test Plan:
- Reset, then entry_req kind=0; keys 1,2,3,ENTER -> key_reject on ENTER, busy stays 1. Then key 4, ENTER -> entry_done, password_out=16'h1234, digit_count=0, busy=0.
- entry_req kind=1; keys 1,2,3,4,ENTER -> entry_done, value_out=20'h004D2, password_out unchanged at 16'h1234.
- Value overflow: kind=1; keys 1,0,4,8,5,7,6 -> key_reject on 6, digit_count=6. ENTER -> value_out=20'h19999 (104857).
- CLEAR/CANCEL: kind=0; keys 9,9,CLEAR -> digit_count=0. Keys 5,CANCEL -> entry_abort pulse, password_out unchanged, busy=0. A key in IDLE produces no reject.
- Invalid code and simultaneity: in COLLECT, key 0xE -> key_reject only. In IDLE, entry_req with key 7 in the same cycle -> digit_count=0.
- Assert rst mid-session after 3 digits -> all outputs 0 immediately. With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES=8: entry_req followed by no keys -> entry_abort 8 cycles later.
